painterengine_gpu_blend_pipe: RTL
=================================

PAINTERENGINE_GPU_BLEND_PIPE -- requirements
Module: painterengine_gpu_blend_pipe

Interface
REQ-001 SHALL have parameter CW, default 8: bits per colour channel (A,R,G,B), legal range 4..12.
REQ-002 SHALL have parameter CNT_W, default 32: width of the output-pixel counter.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1: asynchronous active-low reset.
REQ-005 SHALL have port in_valid  input  1: the source/destination pair on the input bus is valid.
REQ-006 SHALL have port in_ready  output  1: the block accepts input this cycle.
REQ-007 SHALL have port in_src  input  4*CW: source pixel {A,R,G,B}, A in the MSBs.
REQ-008 SHALL have port in_dst  input  4*CW: destination pixel {A,R,G,B}.
REQ-009 SHALL have port in_mode  input  2: blend mode (0 SRC_OVER, 1 ADD_SAT, 2 MULTIPLY, 3 SRC_COPY).
REQ-010 SHALL have port out_valid  output  1: out_pix holds a result.
REQ-011 SHALL have port out_ready  input  1: the downstream consumer accepts out_pix.
REQ-012 SHALL have port out_pix  output  4*CW: blended pixel {A,R,G,B}.
REQ-013 SHALL have port cnt_clear  input  1: synchronous clear of pix_count.
REQ-014 SHALL have port pix_count  output  CNT_W: number of completed output handshakes.

Function
REQ-015 SHALL accept an input when in_valid && in_ready; SHALL complete an output when out_valid && out_ready.
REQ-016 SHALL be a 3-stage pipeline: S1 registers operands and mode; S2 forms products/sums; S3 shifts, saturates and drives out_pix.
REQ-017 SHALL assert out_valid exactly 3 cycles after the accepting edge when there is no stall.
REQ-018 SHALL advance all stages together on advance = !v3 || out_ready, and SHALL drive in_ready = advance (combinational, no path from in_valid).
REQ-019 SHALL sustain 1 pixel/cycle when out_ready is held high; bubbles (valid=0) SHALL propagate with no data loss.
REQ-020 SHALL hold out_pix and out_valid stable while out_valid && !out_ready.
REQ-021 SHALL use M = 2^CW-1. SRC_OVER: c = ((2^CW - a1)*c2 + c1*(a1+1)) >> CW; a = M - (((2^CW - a1)*(M - a2)) >> CW).
REQ-022 ADD_SAT: every channel, alpha included, SHALL equal min(x1+x2, M).
REQ-023 MULTIPLY: colour SHALL equal (c1*(c2+1)) >> CW, and alpha SHALL use the SRC_OVER alpha rule.
REQ-024 SRC_COPY: out_pix SHALL equal in_src unchanged.
REQ-025 SHALL size intermediate products at 2*CW+2 bits so that no overflow occurs before shift or saturation; results SHALL never exceed M.
REQ-026 SHALL carry the mode with its pixel through the stages, so mixed modes in consecutive cycles are legal.
REQ-027 SHALL increment pix_count on each output handshake, wrapping from 2^CNT_W-1 to 0.
REQ-028 If cnt_clear and an output handshake occur in the same cycle, cnt_clear SHALL win and pix_count SHALL become 0.

Reset
REQ-029 On rst_n low, SHALL asynchronously clear v1..v3, out_valid, out_pix and pix_count to 0; in_ready SHALL read 1 once out of reset.
REQ-030 Reset mid-stream SHALL discard all in-flight pixels; no output handshake SHALL occur for them.
REQ-031 Datapath registers other than out_pix MAY be left unreset.

Structure
REQ-032 SHALL place the mode encodings and the channel-slice helper constants in a shared package painterengine_gpu_pkg.
REQ-033 SHALL implement the per-channel arithmetic in one sub-module, painterengine_gpu_blend_lane, instantiated four times (A lane mode-aware).

Verification (CW=8)
REQ-034 SRC_OVER, src {255,200,0,0}, dst {0,10,0,0} -> out A=255, R=200 after 3 cycles.
REQ-035 SRC_OVER, src {0,50,0,0}, dst {128,100,0,0} -> out A=128, R=100.
REQ-036 ADD_SAT, src R=200, dst R=100 -> R=255; MULTIPLY, src R=128, dst R=255 -> R=128; SRC_COPY -> out equals src.
REQ-037 Stream 8 pixels with out_ready low for cycles 4..6 -> no loss or duplication, order preserved, out_pix stable while stalled, in_ready low while stalled with v3 set.
REQ-038 Run 10 handshakes, assert cnt_clear together with the 10th -> pix_count=0; with CNT_W=4, 17 handshakes -> pix_count=1.
REQ-039 Assert rst_n low while 3 pixels are in flight -> out_valid=0 immediately, pix_count=0, and no stale output after release.

Source files
------------

// File: rtl/painterengine_gpu_pkg.sv
// painterengine_gpu_pkg: blend mode encodings, lane ops and channel-slice helpers shared by the blend pipe.
package painterengine_gpu_pkg;
  typedef enum logic [1:0] {
    MODE_SRC_OVER = 2'd0,
    MODE_ADD_SAT  = 2'd1,
    MODE_MULTIPLY = 2'd2,
    MODE_SRC_COPY = 2'd3
  } blend_mode_e;
  typedef enum logic [1:0] {
    OP_SHIFT     = 2'd0,
    OP_INV_SHIFT = 2'd1,
    OP_SAT       = 2'd2,
    OP_COPY      = 2'd3
  } lane_op_e;
  localparam int NUM_CH = 4;
  localparam int CH_A = 3;
  localparam int CH_R = 2;
  localparam int CH_G = 1;
  localparam int CH_B = 0;
  function automatic int ch_lsb(input int ch, input int cw);
    return ch * cw;
  endfunction
endpackage

// File: rtl/painterengine_gpu_blend_lane.sv
// painterengine_gpu_blend_lane: one channel of the blend; S2 product/sum register, S3 shift/saturate (combinational out).
module painterengine_gpu_blend_lane
  import painterengine_gpu_pkg::*;
#(
  parameter int CW = 8,
  parameter bit IS_ALPHA = 1'b0
) (
  input  logic          clk,
  input  logic          en,
  input  logic [1:0]    mode,
  input  logic [CW-1:0] x1,
  input  logic [CW-1:0] x2,
  input  logic [CW-1:0] a1,
  output logic [CW-1:0] res
);
  localparam int PW = 2 * CW + 2;
  localparam logic [CW-1:0] MAXV = {CW{1'b1}};
  localparam logic [PW-1:0] ONE = PW'(1) << CW;
  localparam logic [PW-1:0] MX = PW'(MAXV);
  logic [PW-1:0] e1, e2, ea, inv_a, p_d, p_q;
  logic [CW-1:0] sh;
  lane_op_e op_d, op_q;
  assign e1 = PW'(x1);
  assign e2 = PW'(x2);
  assign ea = PW'(a1);
  assign inv_a = ONE - ea;
  always_comb begin
    op_d = mode == MODE_SRC_COPY ? OP_COPY :
           mode == MODE_ADD_SAT  ? OP_SAT  :
           IS_ALPHA              ? OP_INV_SHIFT : OP_SHIFT;
    // alpha lane uses the SRC_OVER alpha rule for both SRC_OVER and MULTIPLY
    p_d = mode == MODE_SRC_COPY ? e1 :
          mode == MODE_ADD_SAT  ? e1 + e2 :
          IS_ALPHA              ? inv_a * (MX - e2) :
          mode == MODE_MULTIPLY ? e1 * (e2 + PW'(1)) :
                                  inv_a * e2 + e1 * (ea + PW'(1));
  end
  always_ff @(posedge clk) begin
    if (en) begin
      p_q  <= p_d;
      op_q <= op_d;
    end
  end
  assign sh  = CW'(p_q >> CW);
  assign res = op_q == OP_COPY      ? p_q[CW-1:0] :
               op_q == OP_SAT       ? (p_q > MX ? MAXV : p_q[CW-1:0]) :
               op_q == OP_INV_SHIFT ? MAXV - sh : sh;
endmodule

// File: rtl/painterengine_gpu_blend_pipe.sv
// painterengine_gpu_blend_pipe: 3-stage ARGB blend pipeline with valid/ready handshakes and an output pixel counter.
module painterengine_gpu_blend_pipe
  import painterengine_gpu_pkg::*;
#(
  parameter int CW = 8,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4*CW-1:0]   in_src,
  input  logic [4*CW-1:0]   in_dst,
  input  logic [1:0]        in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [4*CW-1:0]   out_pix,
  input  logic              cnt_clear,
  output logic [CNT_W-1:0]  pix_count
);
  localparam int PW = 4 * CW;
  logic advance;
  logic v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
  logic [PW-1:0] src_d, src_q, dst_d, dst_q, pix_d, pix_q, lane_res;
  logic [1:0] mode_d, mode_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  always_comb begin
    advance = !v3_q || out_ready;
    v1_d    = advance ? in_valid : v1_q;
    v2_d    = advance ? v1_q : v2_q;
    v3_d    = advance ? v2_q : v3_q;
    src_d   = advance ? in_src : src_q;
    dst_d   = advance ? in_dst : dst_q;
    mode_d  = advance ? in_mode : mode_q;
    pix_d   = advance && v2_q ? lane_res : pix_q;
    cnt_d   = cnt_clear ? '0 : v3_q && out_ready ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      pix_q <= '0;
      cnt_q <= '0;
    end else begin
      v1_q  <= v1_d;
      v2_q  <= v2_d;
      v3_q  <= v3_d;
      pix_q <= pix_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    src_q  <= src_d;
    dst_q  <= dst_d;
    mode_q <= mode_d;
  end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_lane
    painterengine_gpu_blend_lane #(.CW(CW), .IS_ALPHA(c == CH_A)) u_lane (
      .clk  (clk),
      .en   (advance),
      .mode (mode_q),
      .x1   (src_q[ch_lsb(c, CW) +: CW]),
      .x2   (dst_q[ch_lsb(c, CW) +: CW]),
      .a1   (src_q[ch_lsb(CH_A, CW) +: CW]),
      .res  (lane_res[ch_lsb(c, CW) +: CW])
    );
  end
  assign in_ready  = advance;
  assign out_valid = v3_q;
  assign out_pix   = pix_q;
  assign pix_count = cnt_q;
endmodule
